hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Pipeline sequencing controller for the 5-stage core. Generates freeze (disa), flush and bubble
//  controls for the PC register, the IF/ID latch and the ID/EX latch: load-use stalls, taken-branch
//  flushes, HALT drain-and-stop, and debug single-step. Sits beside the ID stage.
// PARAMETERS
//  REG_W      5   register-index width (rs/rt fields)
//  DRAIN_CYC  3   cycles to drain EX/MEM/WB after HALT is decoded
//  CNT_W      16  width of the stall-cycle performance counter
// PORTS
//  clk           in   1      single clock; all state on posedge clk
//  reset         in   1      asynchronous, active-low reset (0 = reset)
//  id_rs         in   REG_W  rs field of instruction in ID
//  id_rt         in   REG_W  rt field of instruction in ID
//  id_uses_rt    in   1      ID instruction reads rt as a source
//  ex_mem_read   in   1      instruction in EX is a load
//  ex_rt         in   REG_W  destination of the load in EX
//  ex_branch_tkn in   1      branch/jump in EX resolved taken this cycle
//  id_halt       in   1      ID instruction is HALT
//  step_en       in   1      debug single-step mode enable
//  step_pulse    in   1      one-cycle advance request (honoured only when step_en=1)
//  pc_disa       out  1      1 = PC holds its value
//  if_id_disa    out  1      1 = IF/ID latch holds
//  if_id_flush   out  1      1 = IF/ID latch loads NOP (0) next edge
//  id_ex_bubble  out  1      1 = ID/EX latch loads NOP next edge
//  halted        out  1      core stopped after HALT drain
//  stall_cnt     out  CNT_W  saturating count of load-use stall cycles
// BEHAVIOUR
//  - Reset (reset=0): state=RUN, drain counter=0, stall_cnt=0; all outputs 0 while reset is low.
//  - Control outputs are Mealy: combinational from state + current inputs, same-cycle effect.
//  - States: RUN, DRAIN, HALTED. Step mode is a gate on RUN, not a state.
//  - Load-use: lu = ex_mem_read & ex_rt!=0 & (ex_rt==id_rs | (id_uses_rt & ex_rt==id_rt)).
//    lu in RUN -> pc_disa=1, if_id_disa=1, id_ex_bubble=1 for that cycle; stall_cnt+1 (saturates
//    at all-ones, no wrap). Exactly one stall cycle per load (bubble clears EX).
//  - Taken branch (ex_branch_tkn in RUN or DRAIN): if_id_flush=1, id_ex_bubble=1, pc_disa=0.
//    Priority over lu and id_halt in the same cycle (ID instr is wrong-path): no stall, no count,
//    HALT discarded; if in DRAIN, return to RUN and clear drain counter.
//  - HALT: id_halt & no lu & no ex_branch_tkn in RUN -> next state DRAIN, counter=0;
//    that cycle id_ex_bubble=1, pc_disa=1, if_id_disa=1 (HALT is not propagated).
//  - DRAIN: pc_disa=if_id_disa=id_ex_bubble=1; counter increments each cycle;
//    at counter==DRAIN_CYC-1 -> HALTED.
//  - HALTED: pc_disa=if_id_disa=id_ex_bubble=1, halted=1; only exit is reset.
//  - Step mode (step_en=1, state RUN): without step_pulse, pc_disa=if_id_disa=id_ex_bubble=1
//    and no hazard/halt actions are taken; with step_pulse, behaves as a normal RUN cycle (lu
//    and branch rules apply). step_pulse held high = free-run. Step gating ignored in DRAIN/HALTED.
//  - step_en toggling mid-stall: evaluated per cycle; no partial state retained.
//  - Reset asserted mid-DRAIN or in HALTED: immediate return to RUN, counters cleared.
//  - stall_cnt counts only lu-caused stall cycles (not step, drain or halt freezes).
// STRUCTURE
//  - Shared include hazard_defs.vh: state encodings (RUN/DRAIN/HALTED), REG_W, NOP encoding
//    (32'h0), HALT opcode constant; used also by the decoder and pipe latches.
//  - One sub-module: hazard_detect (pure combinational lu comparator, REG_W param);
//    FSM, drain counter and stall counter live in hazard_ctrl.
// TESTING
//  1 lw $2 in EX (ex_rt=2), ID reads rs=2 -> 1 cycle pc_disa=if_id_disa=id_ex_bubble=1, stall_cnt 0->1.
//  2 ex_rt=0 with load, id_rs=0 -> no stall; id_uses_rt=0, ex_rt=id_rt=5 -> no stall.
//  3 lu and ex_branch_tkn same cycle -> if_id_flush=1, id_ex_bubble=1, pc_disa=0, stall_cnt unchanged.
//  4 id_halt in RUN -> DRAIN 3 cycles, halted=1 on cycle 4 and stays; reset=0 -> halted=0, RUN.
//  5 step_en=1, step_pulse every 4th cycle -> PC advances once per pulse; lu on a pulse cycle stalls.
//  6 force stall_cnt to all-ones via repeated lu (CNT_W=4 build) -> holds 4'hF, no wrap.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the hazard controller, the ID-stage decoder and the
// pipe latches: FSM state encodings, the register-index width, the NOP
// instruction word, the HALT opcode and a bundled pipeline-control type.
package hazard_ctrl_pkg;

  localparam int unsigned REG_W_DEF = 5;

  // NOP is the all-zero instruction word; a flushed latch loads this value.
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0000;
  localparam logic [5:0]  HALT_OPCODE = 6'h3F;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  // One bundle of the four latch/PC controls, so the FSM can assign a whole
  // action in a single statement.
  typedef struct packed {
    logic pc_disa;
    logic if_id_disa;
    logic if_id_flush;
    logic id_ex_bubble;
  } pipe_ctl_t;

  localparam pipe_ctl_t CTL_NONE   = '{pc_disa: 1'b0, if_id_disa: 1'b0, if_id_flush: 1'b0, id_ex_bubble: 1'b0};
  // Freeze PC and IF/ID, insert a bubble into ID/EX.
  localparam pipe_ctl_t CTL_FREEZE = '{pc_disa: 1'b1, if_id_disa: 1'b1, if_id_flush: 1'b0, id_ex_bubble: 1'b1};
  // Wrong-path kill: PC takes the branch target, IF/ID and ID/EX get NOPs.
  localparam pipe_ctl_t CTL_FLUSH  = '{pc_disa: 1'b0, if_id_disa: 1'b0, if_id_flush: 1'b1, id_ex_bubble: 1'b1};

  // Saturating increment: holds at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
    return (val == max_val) ? val : val + 32'd1;
  endfunction

endpackage

// File: rtl/hazard_ctrl_detect.sv
// hazard_detect: combinational load-use comparator.
// A load in EX targeting a non-zero register that the ID instruction reads
// (rs always, rt only when the instruction actually sources rt) forces one
// stall cycle.
//   ex_mem_read_i  load in EX
//   ex_rt_i        load destination register
//   id_rs_i        ID rs field
//   id_rt_i        ID rt field
//   id_uses_rt_i   ID instruction reads rt
//   lu_o           load-use hazard present this cycle
module hazard_detect #(
  parameter int unsigned REG_W = 5
) (
  input  logic             ex_mem_read_i,
  input  logic [REG_W-1:0] ex_rt_i,
  input  logic [REG_W-1:0] id_rs_i,
  input  logic [REG_W-1:0] id_rt_i,
  input  logic             id_uses_rt_i,
  output logic             lu_o
);

  logic rs_match;
  logic rt_match;

  assign rs_match = (ex_rt_i == id_rs_i);
  assign rt_match = id_uses_rt_i && (ex_rt_i == id_rt_i);

  // Register 0 is hardwired to zero, so a load into it never creates a hazard.
  assign lu_o = ex_mem_read_i && (ex_rt_i != '0) && (rs_match || rt_match);

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline sequencing controller for the 5-stage core.
// Produces PC/IF-ID freeze, IF-ID flush and ID-EX bubble controls for
// load-use stalls, taken-branch flushes, HALT drain-and-stop and debug
// single-step. Controls are Mealy (state + current inputs) and forced to 0
// while reset is low.
//   clk, reset      clock; asynchronous active-low reset
//   id_rs/id_rt/id_uses_rt, ex_mem_read/ex_rt   load-use inputs
//   ex_branch_tkn   taken branch resolved in EX
//   id_halt         HALT decoded in ID
//   step_en/step_pulse  debug single-step gate
//   pc_disa, if_id_disa, if_id_flush, id_ex_bubble  pipeline controls
//   halted          core stopped after drain
//   stall_cnt       saturating load-use stall-cycle count
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_RUN    | normal issue; hazards, branches, HALT and step gating apply
// ST_DRAIN  | HALT seen; freeze front end while EX/MEM/WB empty out
// ST_HALTED | drained and stopped; only reset leaves
module hazard_ctrl #(
  parameter int unsigned REG_W     = 5,
  parameter int unsigned DRAIN_CYC = 3,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             ex_branch_tkn,
  input  logic             id_halt,
  input  logic             step_en,
  input  logic             step_pulse,
  output logic             pc_disa,
  output logic             if_id_disa,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);

  import hazard_ctrl_pkg::*;

  localparam int unsigned DCW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state_q, state_d;
  logic [DCW-1:0]   drain_q, drain_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  pipe_ctl_t        ctl;
  logic             halted_c;
  logic             lu;

  hazard_detect #(.REG_W(REG_W)) u_detect (
    .ex_mem_read_i (ex_mem_read),
    .ex_rt_i       (ex_rt),
    .id_rs_i       (id_rs),
    .id_rt_i       (id_rt),
    .id_uses_rt_i  (id_uses_rt),
    .lu_o          (lu)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_RUN;
      drain_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      drain_q     <= drain_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    drain_d     = drain_q;
    stall_cnt_d = stall_cnt_q;
    ctl         = CTL_NONE;
    halted_c    = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (step_en && !step_pulse) begin
          // Step mode with no advance request: hold everything, take no action.
          ctl = CTL_FREEZE;
        end else if (ex_branch_tkn) begin
          // ID holds a wrong-path instruction, so its hazard or HALT is moot.
          ctl = CTL_FLUSH;
        end else if (lu) begin
          ctl = CTL_FREEZE;
          if (stall_cnt_q != CNT_MAX) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
          end
        end else if (id_halt) begin
          // HALT is replaced by a bubble; the front end stays frozen from here on.
          ctl     = CTL_FREEZE;
          state_d = ST_DRAIN;
          drain_d = '0;
        end
      end

      ST_DRAIN: begin
        if (ex_branch_tkn) begin
          // A branch older than HALT redirected the stream: HALT was wrong-path.
          ctl     = CTL_FLUSH;
          state_d = ST_RUN;
          drain_d = '0;
        end else begin
          ctl = CTL_FREEZE;
          if (drain_q == DRAIN_LAST) begin
            state_d = ST_HALTED;
          end else begin
            drain_d = drain_q + DCW'(1);
          end
        end
      end

      ST_HALTED: begin
        ctl      = CTL_FREEZE;
        halted_c = 1'b1;
      end

      default: begin
        state_d = ST_RUN;
        drain_d = '0;
      end
    endcase
  end

  // Mealy outputs would otherwise follow live inputs during reset.
  assign pc_disa      = reset & ctl.pc_disa;
  assign if_id_disa   = reset & ctl.if_id_disa;
  assign if_id_flush  = reset & ctl.if_id_flush;
  assign id_ex_bubble = reset & ctl.id_ex_bubble;
  assign halted       = reset & halted_c;
  assign stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  localparam int REG_W = 5;
  localparam int CNT_W = 4;

  // Expected control vectors: {pc_disa, if_id_disa, if_id_flush, id_ex_bubble, halted}
  localparam logic [4:0] C_NONE   = 5'b00000;
  localparam logic [4:0] C_STALL  = 5'b11010;
  localparam logic [4:0] C_FLUSH  = 5'b00110;
  localparam logic [4:0] C_HALTED = 5'b11011;

  logic             clk;
  logic             reset;
  logic [REG_W-1:0] id_rs, id_rt, ex_rt;
  logic             id_uses_rt, ex_mem_read, ex_branch_tkn, id_halt, step_en, step_pulse;
  logic             pc_disa, if_id_disa, if_id_flush, id_ex_bubble, halted;
  logic [CNT_W-1:0] stall_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int adv;

  hazard_ctrl #(.REG_W(REG_W), .DRAIN_CYC(3), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .id_uses_rt    (id_uses_rt),
    .ex_mem_read   (ex_mem_read),
    .ex_rt         (ex_rt),
    .ex_branch_tkn (ex_branch_tkn),
    .id_halt       (id_halt),
    .step_en       (step_en),
    .step_pulse    (step_pulse),
    .pc_disa       (pc_disa),
    .if_id_disa    (if_id_disa),
    .if_id_flush   (if_id_flush),
    .id_ex_bubble  (id_ex_bubble),
    .halted        (halted),
    .stall_cnt     (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] ctl_vec();
    return {pc_disa, if_id_disa, if_id_flush, id_ex_bubble, halted};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    id_rs = '0; id_rt = '0; ex_rt = '0;
    id_uses_rt = 0; ex_mem_read = 0; ex_branch_tkn = 0; id_halt = 0;
    step_en = 0; step_pulse = 0;
  endtask

  // Advance past one rising edge; inputs change and checks happen mid-cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lu(input logic [REG_W-1:0] r);
    ex_mem_read = 1; ex_rt = r; id_rs = r;
  endtask

  initial begin
    idle();
    reset = 0;
    #2;
    chk("reset_ctl", ctl_vec(), C_NONE);
    chk("reset_cnt", stall_cnt, 0);
    set_lu(5'd3); id_halt = 1; #1;
    chk("reset_ctl_gated", ctl_vec(), C_NONE);
    tick();
    chk("reset_cnt_held", stall_cnt, 0);
    idle();
    reset = 1;
    #1;
    chk("run_idle", ctl_vec(), C_NONE);

    // 1: basic load-use on rs
    set_lu(5'd2); #1;
    chk("lu_rs_ctl", ctl_vec(), C_STALL);
    tick(); idle(); #1;
    chk("lu_rs_after", ctl_vec(), C_NONE);
    chk("lu_rs_cnt", stall_cnt, 1);

    // 2: no stall on r0, no stall when rt not used
    ex_mem_read = 1; ex_rt = 0; id_rs = 0; #1;
    chk("lu_r0", ctl_vec(), C_NONE);
    ex_rt = 5; id_rt = 5; id_rs = 1; id_uses_rt = 0; #1;
    chk("lu_rt_unused", ctl_vec(), C_NONE);
    id_uses_rt = 1; #1;
    chk("lu_rt_used", ctl_vec(), C_STALL);
    ex_mem_read = 0; #1;
    chk("no_load", ctl_vec(), C_NONE);
    tick();
    chk("cnt_unchanged_2", stall_cnt, 1);

    // 3: branch beats load-use
    set_lu(5'd7); ex_branch_tkn = 1; id_halt = 1; #1;
    chk("br_over_lu", ctl_vec(), C_FLUSH);
    tick(); idle(); #1;
    chk("br_cnt", stall_cnt, 1);
    chk("br_halt_dropped", ctl_vec(), C_NONE);

    // 5: single-step
    step_en = 1; #1;
    chk("step_hold", ctl_vec(), C_STALL);
    set_lu(5'd4); #1;
    chk("step_hold_lu", ctl_vec(), C_STALL);
    tick();
    chk("step_hold_nocnt", stall_cnt, 1);
    ex_mem_read = 0; ex_branch_tkn = 1; #1;
    chk("step_hold_br", ctl_vec(), C_STALL);
    ex_branch_tkn = 0; id_halt = 1; tick(); id_halt = 0; #1;
    chk("step_halt_ignored", ctl_vec(), C_STALL);
    step_pulse = 1; #1;
    chk("step_pulse_run", ctl_vec(), C_NONE);
    set_lu(5'd4); #1;
    chk("step_pulse_lu", ctl_vec(), C_STALL);
    tick(); idle(); #1;
    chk("step_pulse_cnt", stall_cnt, 2);
    step_en = 1;
    adv = 0;
    for (int i = 0; i < 8; i++) begin
      step_pulse = (i % 4 == 3);
      #1;
      if (!pc_disa) adv++;
      tick();
    end
    chk("step_adv_count", adv, 2);
    idle();
    step_en = 1; step_pulse = 1; #1;
    chk("step_freerun", ctl_vec(), C_NONE);
    idle();

    // 4: HALT, branch during DRAIN aborts it
    id_halt = 1; #1;
    chk("halt_ctl", ctl_vec(), C_STALL);
    tick(); idle(); #1;
    chk("drain_abort_c1", ctl_vec(), C_STALL);
    ex_branch_tkn = 1; #1;
    chk("drain_br_flush", ctl_vec(), C_FLUSH);
    tick(); idle(); #1;
    chk("drain_br_run", ctl_vec(), C_NONE);

    // 4: full HALT drain, step gating ignored in DRAIN
    id_halt = 1; tick(); idle();
    step_en = 1; #1;
    chk("drain_c1", ctl_vec(), C_STALL);
    tick(); #1;
    chk("drain_c2", ctl_vec(), C_STALL);
    tick(); #1;
    chk("drain_c3", ctl_vec(), C_STALL);
    tick(); idle(); #1;
    chk("halted_c4", ctl_vec(), C_HALTED);
    ex_branch_tkn = 1; set_lu(5'd9);
    tick(); tick(); #1;
    chk("halted_stays", ctl_vec(), C_HALTED);
    chk("halted_nocnt", stall_cnt, 2);
    idle();
    reset = 0; #1;
    chk("halted_reset", ctl_vec(), C_NONE);
    chk("halted_reset_cnt", stall_cnt, 0);
    reset = 1; #1;
    chk("after_reset_run", ctl_vec(), C_NONE);
    set_lu(5'd1); #1;
    chk("after_reset_lu", ctl_vec(), C_STALL);
    tick(); idle(); #1;
    chk("after_reset_cnt", stall_cnt, 1);

    // Reset mid-DRAIN
    id_halt = 1; tick(); idle(); tick(); #1;
    chk("mid_drain", ctl_vec(), C_STALL);
    reset = 0; #1;
    chk("mid_drain_reset", ctl_vec(), C_NONE);
    tick();
    reset = 1; tick(); #1;
    chk("mid_drain_run", ctl_vec(), C_NONE);

    // 6: saturation of the 4-bit counter
    set_lu(5'd6);
    for (int i = 0; i < 14; i++) tick();
    chk("sat_14", stall_cnt, 14);
    for (int i = 0; i < 6; i++) tick();
    chk("sat_hold", stall_cnt, 15);
    chk("sat_still_stall", ctl_vec(), C_STALL);
    idle();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
